// File: rtl/sme_string_match.sv
// sme_string_match
//   Byte-serial string-matching engine. A text string (up to STR_MAX chars)
//   is stored, then each pattern (up to PAT_MAX chars) is searched for in it.
//   The result for each pattern is presented with a one-cycle valid pulse.
//
//   Pattern metacharacters:
//     '.'  any single char
//     '^'  (first char only) match must start at index 0 or right after a space
//     '$'  (last char only) match must end at end of string or before a space
//     '*'  (first one only) zero or more arbitrary chars
//
// Ports
//   clk          rising-edge clock
//   reset        synchronous, active-low reset
//   chardata     character byte, valid while isstring or ispattern is high
//   isstring     current byte belongs to the text string
//   ispattern    current byte belongs to a pattern
//   valid        one-cycle pulse, match/match_index carry the latest result
//   match        pattern found in stored string
//   match_index  start index of leftmost match, 0 when no match
module sme_string_match #(
  parameter int STR_MAX = 32,
  parameter int PAT_MAX = 8
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [7:0]                 chardata,
  input  logic                       isstring,
  input  logic                       ispattern,
  output logic                       valid,
  output logic                       match,
  output logic [$clog2(STR_MAX)-1:0] match_index
);

  localparam int IW  = $clog2(STR_MAX);
  localparam int LW  = $clog2(STR_MAX + 1);
  localparam int PW  = $clog2(PAT_MAX);
  localparam int PLW = $clog2(PAT_MAX + 1);

  localparam logic [2:0] ST_IDLE     = 3'd0;
  localparam logic [2:0] ST_LOAD_STR = 3'd1;
  localparam logic [2:0] ST_LOAD_PAT = 3'd2;
  localparam logic [2:0] ST_MATCH    = 3'd3;
  localparam logic [2:0] ST_OUT      = 3'd4;

  localparam logic [7:0] CH_ANCHOR = 8'h5E;
  localparam logic [7:0] CH_DOLLAR = 8'h24;
  localparam logic [7:0] CH_STAR   = 8'h2A;
  localparam logic [7:0] CH_DOT    = 8'h2E;
  localparam logic [7:0] CH_SPACE  = 8'h20;

  logic [2:0]     state;
  logic [7:0]     str_mem [STR_MAX];
  logic [LW-1:0]  str_len;
  logic [7:0]     pat_mem [PAT_MAX];
  logic [PLW-1:0] pat_len;

  // Match-phase registers. phase 0 scans candidate suffix positions downward,
  // phase 1 scans start positions upward.
  logic           phase;
  logic [LW-1:0]  pos;
  logic [LW-1:0]  t_max;
  logic           anchor_q, dollar_q, star_q;
  logic [PLW-1:0] a_off_q, a_len_q, b_off_q, b_len_q;

  // Pattern decode: split the body (pattern minus '^' and '$') into the part
  // before the star (A) and the part after it (B). A pattern with no ordinary
  // characters drops its '$' so that it matches at index 0.
  logic           d_anchor, d_dollar, d_star, raw_dollar;
  logic [PLW-1:0] lo, hi, star_at;
  logic [PLW-1:0] d_a_off, d_a_len, d_b_off, d_b_len;
  logic [PW-1:0]  last_i;

  always_comb begin
    d_anchor   = (pat_len != '0) && (pat_mem[0] == CH_ANCHOR);
    lo         = d_anchor ? PLW'(1) : '0;
    last_i     = pat_len[PW-1:0] - PW'(1);
    raw_dollar = (pat_len > lo) && (pat_mem[last_i] == CH_DOLLAR);
    hi         = raw_dollar ? (pat_len - PLW'(1)) : pat_len;
    d_star     = 1'b0;
    star_at    = hi;
    for (int k = 0; k < PAT_MAX; k++) begin
      if (!d_star && (PLW'(k) >= lo) && (PLW'(k) < hi) && (pat_mem[k] == CH_STAR)) begin
        d_star  = 1'b1;
        star_at = PLW'(k);
      end
    end
    d_a_off  = lo;
    d_a_len  = star_at - lo;
    d_b_off  = star_at + PLW'(1);
    d_b_len  = d_star ? (hi - star_at - PLW'(1)) : '0;
    d_dollar = raw_dollar && ((d_a_len + d_b_len) != '0);
  end

  // Window comparator: does segment A or B match the string at pos, and
  // (if required) is the end of the segment followed by end-of-string or space.
  logic           win_ok, chk_dollar, anchor_ok, reach_ok, start_ok;
  logic [PLW-1:0] seg_off, seg_len, pi;
  logic [LW-1:0]  si, endp;
  logic [IW-1:0]  prev_i;

  always_comb begin
    seg_off    = phase ? a_off_q : b_off_q;
    seg_len    = phase ? a_len_q : b_len_q;
    chk_dollar = phase ? (dollar_q && !star_q) : dollar_q;
    win_ok     = 1'b1;
    pi         = '0;
    si         = '0;
    for (int i = 0; i < PAT_MAX; i++) begin
      if (PLW'(i) < seg_len) begin
        pi = seg_off + PLW'(i);
        si = pos + LW'(i);
        if ((si >= str_len) || (pi >= PLW'(PAT_MAX))) begin
          win_ok = 1'b0;
        end else if ((pat_mem[pi[PW-1:0]] != CH_DOT) &&
                     (pat_mem[pi[PW-1:0]] != str_mem[si[IW-1:0]])) begin
          win_ok = 1'b0;
        end
      end
    end
    endp = pos + LW'(seg_len);
    if (chk_dollar) begin
      if (endp > str_len) begin
        win_ok = 1'b0;
      end else if ((endp != str_len) && (str_mem[endp[IW-1:0]] != CH_SPACE)) begin
        win_ok = 1'b0;
      end
    end
    prev_i    = pos[IW-1:0] - IW'(1);
    anchor_ok = !anchor_q || (pos == '0) || (str_mem[prev_i] == CH_SPACE);
    // With a star, A must finish no later than the rightmost place B can start.
    reach_ok  = !star_q || ((pos + LW'(a_len_q)) <= t_max);
    start_ok  = win_ok && anchor_ok && reach_ok;
  end

  // Loading, match sequencing and result registers. A string character always
  // wins, which also aborts any search in progress.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state       <= ST_IDLE;
      str_len     <= '0;
      pat_len     <= '0;
      valid       <= 1'b0;
      match       <= 1'b0;
      match_index <= '0;
      phase       <= 1'b0;
      pos         <= '0;
      t_max       <= '0;
      anchor_q    <= 1'b0;
      dollar_q    <= 1'b0;
      star_q      <= 1'b0;
      a_off_q     <= '0;
      a_len_q     <= '0;
      b_off_q     <= '0;
      b_len_q     <= '0;
    end else begin
      valid <= 1'b0;
      if (isstring) begin
        if (state != ST_LOAD_STR) begin
          str_mem[0] <= chardata;
          str_len    <= LW'(1);
          state      <= ST_LOAD_STR;
        end else if (str_len < LW'(STR_MAX)) begin
          str_mem[str_len[IW-1:0]] <= chardata;
          str_len                  <= str_len + LW'(1);
        end
      end else if (ispattern && (state != ST_MATCH) && (state != ST_OUT)) begin
        if (state != ST_LOAD_PAT) begin
          pat_mem[0] <= chardata;
          pat_len    <= PLW'(1);
          state      <= ST_LOAD_PAT;
        end else if (pat_len < PLW'(PAT_MAX)) begin
          pat_mem[pat_len[PW-1:0]] <= chardata;
          pat_len                  <= pat_len + PLW'(1);
        end
      end else begin
        case (state)
          ST_LOAD_STR: state <= ST_IDLE;
          ST_LOAD_PAT: begin
            anchor_q <= d_anchor;
            dollar_q <= d_dollar;
            star_q   <= d_star;
            a_off_q  <= d_a_off;
            a_len_q  <= d_a_len;
            b_off_q  <= d_b_off;
            b_len_q  <= d_b_len;
            phase    <= !d_star;
            pos      <= d_star ? str_len : '0;
            state    <= ST_MATCH;
          end
          ST_MATCH: begin
            if (!phase) begin
              if (win_ok) begin
                t_max <= pos;
                phase <= 1'b1;
                pos   <= '0;
              end else if (pos == '0) begin
                match       <= 1'b0;
                match_index <= '0;
                valid       <= 1'b1;
                state       <= ST_OUT;
              end else begin
                pos <= pos - LW'(1);
              end
            end else begin
              if (pos >= str_len) begin
                match       <= 1'b0;
                match_index <= '0;
                valid       <= 1'b1;
                state       <= ST_OUT;
              end else if (start_ok) begin
                match       <= 1'b1;
                match_index <= pos[IW-1:0];
                valid       <= 1'b1;
                state       <= ST_OUT;
              end else begin
                pos <= pos + LW'(1);
              end
            end
          end
          ST_OUT:  state <= ST_IDLE;
          default: state <= ST_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_sme_string_match.sv
// tb_sme_string_match
//   Directed bench for sme_string_match. A brute-force reference model works
//   out each expected result from the text and pattern; a compare process
//   checks every valid pulse against it and checks that the outputs hold
//   between pulses. Literal expectations pin the model on known cases.
module tb_sme_string_match;

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] chardata;
  logic       isstring;
  logic       ispattern;
  logic       valid;
  logic       match;
  logic [4:0] match_index;

  int         checks = 0;
  int         failures = 0;
  int         valid_seen = 0;
  string      cur_str = "";
  bit         pending = 1'b0;
  bit         exp_m = 1'b0;
  logic [4:0] exp_i = '0;
  bit         held_m = 1'b0;
  logic [4:0] held_i = '0;

  always #5 clk = ~clk;

  sme_string_match dut (
    .clk         (clk),
    .reset       (reset),
    .chardata    (chardata),
    .isstring    (isstring),
    .ispattern   (ispattern),
    .valid       (valid),
    .match       (match),
    .match_index (match_index)
  );

  // Does segment q (with '.' wildcards) fit the text at position pos?
  function automatic bit seg_at(input string s, input byte q[$], input int pos);
    for (int i = 0; i < q.size(); i++) begin
      if (pos + i >= s.len()) return 1'b0;
      if (q[i] != 8'h2E && q[i] != s[pos + i]) return 1'b0;
    end
    return 1'b1;
  endfunction

  function automatic bit end_ok(input string s, input int e);
    return (e == s.len()) || ((e < s.len()) && (s[e] == 8'h20));
  endfunction

  // Reference: try every start, and with a star try every extension.
  function automatic void model(input string s, input string p, output bit m, output int idx);
    byte a[$];
    byte b[$];
    bit  anchor, dollar, star, ok;
    int  lo, hi;
    m = 1'b0;
    idx = 0;
    anchor = (p.len() > 0) && (p[0] == 8'h5E);
    lo = anchor ? 1 : 0;
    hi = p.len();
    dollar = (hi > lo) && (p[hi - 1] == 8'h24);
    if (dollar) hi--;
    star = 1'b0;
    for (int k = lo; k < hi; k++) begin
      if (p[k] == 8'h2A && !star) star = 1'b1;
      else if (star) b.push_back(p[k]);
      else a.push_back(p[k]);
    end
    if (a.size() + b.size() == 0) dollar = 1'b0;
    for (int st = 0; st < s.len() && !m; st++) begin
      ok = !anchor || st == 0 || s[st - 1] == 8'h20;
      ok = ok && seg_at(s, a, st);
      if (ok) begin
        if (!star) begin
          ok = !dollar || end_ok(s, st + a.size());
        end else begin
          ok = 1'b0;
          for (int t = st + a.size(); t <= s.len(); t++) begin
            if (seg_at(s, b, t) && (!dollar || end_ok(s, t + b.size()))) ok = 1'b1;
          end
        end
      end
      if (ok) begin
        m = 1'b1;
        idx = st;
      end
    end
  endfunction

  // Compare process: every valid pulse against the model, every other
  // cycle the outputs must hold the last reported result.
  always @(negedge clk) begin
    if (reset) begin
      if (valid) begin
        valid_seen++;
        checks++;
        if (!pending) begin
          failures++;
          $display("[TB] FAIL unexpected_valid: valid=1 match=%0b idx=%0d, required no pulse", match, match_index);
        end else if (match !== exp_m || match_index !== exp_i) begin
          failures++;
          $display("[TB] FAIL model_compare '%s': match=%0b idx=%0d, required match=%0b idx=%0d",
                   cur_str, match, match_index, exp_m, exp_i);
        end
        held_m = exp_m;
        held_i = exp_i;
        pending = 1'b0;
      end else begin
        checks++;
        if (match !== held_m || match_index !== held_i) begin
          failures++;
          $display("[TB] FAIL hold: match=%0b idx=%0d, required match=%0b idx=%0d",
                   match, match_index, held_m, held_i);
        end
      end
    end
  end

  // Send a string or a pattern; for a pattern optionally wait for its result.
  task automatic applyStimulus(input string txt, input bit is_pat, input bit wait_result);
    int v0;
    int idx;
    bit m;
    bit got;
    if (!is_pat) cur_str = txt;
    if (is_pat && wait_result) begin
      model(cur_str, txt, m, idx);
      exp_m = m;
      exp_i = idx[4:0];
      pending = 1'b1;
    end
    for (int i = 0; i < txt.len(); i++) begin
      @(negedge clk);
      chardata  = txt[i];
      isstring  = !is_pat;
      ispattern = is_pat;
    end
    @(negedge clk);
    isstring  = 1'b0;
    ispattern = 1'b0;
    chardata  = 8'h00;
    if (is_pat && wait_result) begin
      v0 = valid_seen;
      got = 1'b0;
      for (int c = 0; c < 300 && !got; c++) begin
        @(negedge clk);
        #1;
        if (valid_seen != v0) got = 1'b1;
      end
      checks++;
      if (!got) begin
        failures++;
        pending = 1'b0;
        $display("[TB] FAIL timeout '%s': valid=0, required a pulse within 300 cycles", txt);
      end
    end
  endtask

  task automatic checkOutput(input string name, input bit em, input logic [4:0] ei);
    checks++;
    if (match !== em || match_index !== ei) begin
      failures++;
      $display("[TB] FAIL %s: match=%0b idx=%0d, required match=%0b idx=%0d",
               name, match, match_index, em, ei);
    end
  endtask

  task automatic doReset();
    @(negedge clk);
    reset = 1'b0;
    pending = 1'b0;
    @(negedge clk);
    held_m = 1'b0;
    held_i = '0;
    @(negedge clk);
    reset = 1'b1;
  endtask

  initial begin
    int v0;
    reset     = 1'b0;
    chardata  = 8'h00;
    isstring  = 1'b0;
    ispattern = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    checkOutput("reset_state", 1'b0, 5'd0);
    checks++;
    if (valid !== 1'b0) begin
      failures++;
      $display("[TB] FAIL reset_valid: valid=%0b, required 0", valid);
    end

    applyStimulus("hello world", 1'b0, 1'b0);
    applyStimulus("world", 1'b1, 1'b1); checkOutput("world", 1'b1, 5'd6);
    applyStimulus("w.r", 1'b1, 1'b1);   checkOutput("w.r", 1'b1, 5'd6);
    applyStimulus("wxr", 1'b1, 1'b1);   checkOutput("wxr", 1'b0, 5'd0);

    applyStimulus("abc abd", 1'b0, 1'b0);
    applyStimulus("^abd", 1'b1, 1'b1);  checkOutput("^abd", 1'b1, 5'd4);
    applyStimulus("^bc", 1'b1, 1'b1);   checkOutput("^bc", 1'b0, 5'd0);
    applyStimulus("bc$", 1'b1, 1'b1);   checkOutput("bc$", 1'b1, 5'd1);
    applyStimulus("ab$", 1'b1, 1'b1);   checkOutput("ab$", 1'b0, 5'd0);
    applyStimulus("abd$", 1'b1, 1'b1);  checkOutput("abd$", 1'b1, 5'd4);

    applyStimulus("the cat sat", 1'b0, 1'b0);
    applyStimulus("c*t", 1'b1, 1'b1);   checkOutput("c*t", 1'b1, 5'd4);
    applyStimulus("x*t", 1'b1, 1'b1);   checkOutput("x*t", 1'b0, 5'd0);
    applyStimulus("s.t$", 1'b1, 1'b1);  checkOutput("s.t$", 1'b1, 5'd8);

    applyStimulus("abcdefghijklmnopqrstuvwxyz012345", 1'b0, 1'b0);
    applyStimulus("yz012345", 1'b1, 1'b1); checkOutput("tail8", 1'b1, 5'd24);
    applyStimulus("45xyz", 1'b1, 1'b1);    checkOutput("overrun", 1'b0, 5'd0);
    applyStimulus("$", 1'b1, 1'b1);        checkOutput("only_dollar", 1'b1, 5'd0);
    applyStimulus("*5$", 1'b1, 1'b1);      checkOutput("star_dollar", 1'b1, 5'd0);
    applyStimulus("k.m", 1'b1, 1'b1);      checkOutput("k.m", 1'b1, 5'd10);

    // New string while a long search is running aborts it.
    applyStimulus("zz", 1'b1, 1'b0);
    applyStimulus("xy zz", 1'b0, 1'b0);
    applyStimulus("zz", 1'b1, 1'b1);       checkOutput("after_abort", 1'b1, 5'd3);

    // Reset in the middle of a search: no pulse, outputs cleared, string gone.
    applyStimulus("abcdefghijklmnopqrstuvwxyz012345", 1'b0, 1'b0);
    applyStimulus("zz", 1'b1, 1'b0);
    repeat (2) @(negedge clk);
    v0 = valid_seen;
    doReset();
    repeat (100) @(negedge clk);
    checkOutput("reset_mid_match", 1'b0, 5'd0);
    checks++;
    if (valid_seen != v0) begin
      failures++;
      $display("[TB] FAIL reset_mid_no_valid: pulses=%0d, required 0", valid_seen - v0);
    end
    cur_str = "";
    applyStimulus("a", 1'b1, 1'b1);        checkOutput("empty_string", 1'b0, 5'd0);

    repeat (5) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
